// File: rtl/video_frame_monitor.sv
// Tracks panel sync timing per pixel strobe, locks after consecutive clean frames,
// and emits active-window pixel coordinates, frame pulses and sync error statistics.
module video_frame_monitor #(
    parameter int H_TOTAL     = 1056,
    parameter int V_TOTAL     = 525,
    parameter int H_ACT_START = 50,
    parameter int H_ACT_W     = 800,
    parameter int V_ACT_START = 23,
    parameter int V_ACT_H     = 480,
    parameter int C_W         = 8,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_pix_en,
    input  logic                       i_hsd,
    input  logic                       i_vsd,
    input  logic [C_W-1:0]             i_r,
    input  logic [C_W-1:0]             i_g,
    input  logic [C_W-1:0]             i_b,
    output logic                       o_pix_valid,
    output logic [$clog2(H_ACT_W)-1:0] o_x,
    output logic [$clog2(V_ACT_H)-1:0] o_y,
    output logic [3*C_W-1:0]           o_rgb,
    output logic                       o_frame_done,
    output logic [15:0]                o_frame_cnt,
    output logic                       o_locked,
    output logic                       o_sync_err,
    output logic [15:0]                o_err_cnt
);

    localparam int XW  = $clog2(H_TOTAL);
    localparam int YW  = $clog2(V_TOTAL);
    localparam int XOW = $clog2(H_ACT_W);
    localparam int YOW = $clog2(V_ACT_H);
    localparam int GW  = $clog2(LOCK_FRAMES + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t           state, state_next;
    logic             hsd_q, vsd_q;
    logic [XW-1:0]    xcnt, xcnt_next;
    logic [YW-1:0]    ycnt, ycnt_next;
    logic [GW-1:0]    good_cnt, good_next;
    logic [3*C_W-1:0] rgb_q;
    logic             h_fall, v_fall, x_last, y_last, y_wrap, viol, in_active;

    // xcnt/ycnt hold the position of the pixel whose colour sits in rgb_q
    always_comb begin
        h_fall    = hsd_q & ~i_hsd;
        v_fall    = vsd_q & ~i_vsd;
        x_last    = (xcnt == X_LAST);
        y_last    = (ycnt == Y_LAST);
        xcnt_next = (h_fall || x_last) ? '0 : xcnt + XW'(1);
        ycnt_next = ycnt;
        if (v_fall)
            ycnt_next = '0;
        else if (xcnt_next == '0)
            ycnt_next = y_last ? '0 : ycnt + YW'(1);
        y_wrap    = !v_fall && (xcnt_next == '0) && y_last;
        viol      = (h_fall && !x_last) || (!h_fall && x_last) ||
                    (v_fall && !h_fall) || (v_fall && !y_last) || y_wrap;
        in_active = (int'(xcnt) >= H_ACT_START) && (int'(xcnt) < H_ACT_START + H_ACT_W) &&
                    (int'(ycnt) >= V_ACT_START) && (int'(ycnt) < V_ACT_START + V_ACT_H);
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_next = CHECK;
                    good_next  = '0;
                end
            end
            CHECK: begin
                if (viol) begin
                    state_next = SEARCH;
                end else if (v_fall) begin
                    good_next = good_cnt + GW'(1);
                    if (good_next == GW'(LOCK_FRAMES))
                        state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (viol)
                    state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= SEARCH;
        else if (i_pix_en)
            state <= state_next;
    end

    assign o_locked = (state == LOCKED);

    // Pulse outputs drop on every non-strobe cycle so they stay one clock wide
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hsd_q        <= 1'b1;
            vsd_q        <= 1'b1;
            xcnt         <= '0;
            ycnt         <= '0;
            good_cnt     <= '0;
            rgb_q        <= '0;
            o_pix_valid  <= 1'b0;
            o_x          <= '0;
            o_y          <= '0;
            o_rgb        <= '0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= '0;
            o_sync_err   <= 1'b0;
            o_err_cnt    <= '0;
        end else begin
            o_pix_valid  <= 1'b0;
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
            if (i_pix_en) begin
                hsd_q    <= i_hsd;
                vsd_q    <= i_vsd;
                xcnt     <= xcnt_next;
                ycnt     <= ycnt_next;
                good_cnt <= good_next;
                rgb_q    <= {i_r, i_g, i_b};
                if (state != SEARCH && viol) begin
                    o_sync_err <= 1'b1;
                    if (o_err_cnt != 16'hFFFF)
                        o_err_cnt <= o_err_cnt + 16'd1;
                end
                if (state == LOCKED && !viol && v_fall) begin
                    o_frame_done <= 1'b1;
                    o_frame_cnt  <= o_frame_cnt + 16'd1;
                end
                if (state == LOCKED && !viol && in_active) begin
                    o_pix_valid <= 1'b1;
                    o_x         <= XOW'(int'(xcnt) - H_ACT_START);
                    o_y         <= YOW'(int'(ycnt) - V_ACT_START);
                    o_rgb       <= rgb_q;
                end
            end
        end
    end

endmodule
